subclock_arbiter: RTL

- Shares one dynamic clock-divider counter among NREQ requesters; each requests a burst of CNT output periods at half-period DIV (in CLK cycles).
- Round-robin arbitration, latches the winner's settings, generates OUTCLK for exactly CNT periods, pulses DONE to the owner, then releases.
- Sits between rate consumers (UART bit timers, tone generators, blinkers) and the shared divider resource; replaces per-consumer fixed dividers.

---
 rtl/subclock_arbiter_if.sv | 19 +
 rtl/subclock_arbiter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/subclock_arbiter_if.sv
// rtl/subclock_arbiter_if.sv - requester/arbiter bundle for the shared sub-clock divider
interface subclock_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DW   = 26,
  parameter int CW   = 16,
  parameter int IW   = 2
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] div;
  logic [NREQ*CW-1:0] cnt;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic               busy;
  logic [IW-1:0]      cur;
  logic               outclk;

  modport master (output req, div, cnt, input gnt, done, busy, cur, outclk);
  modport slave  (input req, div, cnt, output gnt, done, busy, cur, outclk);
endinterface

// File: rtl/subclock_arbiter.sv
// rtl/subclock_arbiter.sv - round-robin owner of one divider emitting CNT periods of 2*DIV clocks
// SUBCLK_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins) instead of round robin.
module subclock_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 26,
  parameter int CW   = 16,
  parameter int IW   = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  subclock_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_e;

  state_e          state_q;
  logic [NREQ-1:0] gnt_q;
  logic [NREQ-1:0] done_q;
  logic            busy_q;
  logic            outclk_q;
  logic [IW-1:0]   cur_q;
  logic [DW-1:0]   divl_q;
  logic [DW-1:0]   hcnt_q;
  logic [CW-1:0]   pcnt_q;
`ifndef SUBCLK_ARB_FIXED_PRIO_EN
  logic [IW-1:0]   last_q;
`endif

  logic [DW-1:0]   div_a [NREQ];
  logic [CW-1:0]   cnt_a [NREQ];
  logic            win_vld_d;
  logic [IW-1:0]   win_idx_d;
  logic [DW-1:0]   divl_d;
  logic [CW-1:0]   pcnt_d;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      div_a[i] = bus.div[i*DW +: DW];
      cnt_a[i] = bus.cnt[i*CW +: CW];
    end
  end

  always_comb begin
    int j;
    j         = 0;
    win_vld_d = 1'b0;
    win_idx_d = '0;
`ifdef SUBCLK_ARB_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[IW'(i)]) begin
        win_vld_d = 1'b1;
        win_idx_d = IW'(i);
      end
    end
`else
    // Walk from the farthest candidate to the nearest so the first set bit after last wins.
    for (int k = NREQ; k >= 1; k--) begin
      j = int'(last_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (bus.req[IW'(j)]) begin
        win_vld_d = 1'b1;
        win_idx_d = IW'(j);
      end
    end
`endif
    divl_d = (div_a[win_idx_d] == '0) ? DW'(1) : div_a[win_idx_d];
    pcnt_d = (cnt_a[win_idx_d] == '0) ? CW'(1) : cnt_a[win_idx_d];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      outclk_q <= 1'b0;
      cur_q    <= '0;
      divl_q   <= DW'(1);
      hcnt_q   <= '0;
      pcnt_q   <= '0;
`ifndef SUBCLK_ARB_FIXED_PRIO_EN
      last_q   <= IW'(NREQ - 1);
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= '0;
          if (win_vld_d) begin
            state_q  <= RUN;
            gnt_q    <= NREQ'(1) << win_idx_d;
            busy_q   <= 1'b1;
            cur_q    <= win_idx_d;
            divl_q   <= divl_d;
            pcnt_q   <= pcnt_d;
            hcnt_q   <= '0;
            outclk_q <= 1'b0;
`ifndef SUBCLK_ARB_FIXED_PRIO_EN
            last_q   <= win_idx_d;
`endif
          end
        end
        RUN: begin
          if (!bus.req[cur_q]) begin
            // Owner withdrew: release silently, no completion pulse.
            state_q  <= IDLE;
            gnt_q    <= '0;
            busy_q   <= 1'b0;
            outclk_q <= 1'b0;
          end else if (hcnt_q == divl_q - DW'(1)) begin
            hcnt_q   <= '0;
            outclk_q <= ~outclk_q;
            if (outclk_q) begin
              pcnt_q <= pcnt_q - CW'(1);
              if (pcnt_q == CW'(1)) begin
                state_q <= FIN;
                gnt_q   <= '0;
                busy_q  <= 1'b0;
                done_q  <= gnt_q;
              end
            end
          end else begin
            hcnt_q <= hcnt_q + DW'(1);
          end
        end
        FIN: begin
          done_q  <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.gnt    = gnt_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;
  assign bus.cur    = cur_q;
  assign bus.outclk = outclk_q;

endmodule
